// File: rtl/bot_host_if.sv
// Byte-wide AXI-Stream link used for the Bulk-Out/Bulk-In pipes and the
// host-side data source/sink of bot_host.
//   tvalid : beat valid (master -> slave)
//   tready : beat accepted when high together with tvalid (slave -> master)
//   tlast  : last beat of packet/transfer (master -> slave)
//   tdata  : data byte (master -> slave)
interface bot_host_if;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic [7:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/bot_host.sv
// Host-side USB Mass Storage Bulk-Only Transport engine.
// Takes one SCSI command, sends the 31-byte CBW on the Bulk-Out pipe, moves the
// data phase in the commanded direction, then receives and checks the 13-byte CSW.
//   clock, reset     : system clock, asynchronous active-low reset
//   cmd_*            : command request (valid/ready handshake, accepted only when idle)
//   usb_tx (master)  : Bulk-Out pipe to the device (CBW and write data)
//   usb_rx (slave)   : Bulk-In pipe from the device (read data and CSW)
//   dat_wr (slave)   : write-data source for data-out commands
//   dat_rd (master)  : read-data sink for data-in commands
//   sts_*            : one-cycle completion pulse with CSW contents and error flag
//   busy_o           : high whenever the engine is not idle
module bot_host #(
   parameter int unsigned MAX_PACKET = 512,
   parameter logic [31:0] TAG_INIT   = 32'h0000_0001
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  logic         cmd_dir_i,
   input  logic [3:0]   cmd_lun_i,
   input  logic [31:0]  cmd_len_i,
   input  logic [4:0]   cmd_cblen_i,
   input  logic [127:0] cmd_cb_i,
   bot_host_if.master   usb_tx,
   bot_host_if.slave    usb_rx,
   bot_host_if.slave    dat_wr,
   bot_host_if.master   dat_rd,
   output logic         sts_valid_o,
   output logic [31:0]  sts_tag_o,
   output logic [31:0]  sts_residue_o,
   output logic [7:0]   sts_status_o,
   output logic         sts_error_o,
   output logic         busy_o
);

   localparam int unsigned    PktW    = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;
   localparam logic [PktW-1:0] PktLast = PktW'(MAX_PACKET - 1);
   localparam logic [31:0]    CswSig  = 32'h5342_5355;

   typedef enum logic [2:0] {StIdle, StCbw, StDout, StDin, StCsw, StDone} state_e;

   state_e          state_q, state_d;
   logic [31:0]     tag_q, tag_d;
   logic            dir_q, dir_d;
   logic [3:0]      lun_q, lun_d;
   logic [31:0]     len_q, len_d;
   logic [4:0]      cblen_q, cblen_d;
   logic [127:0]    cb_q, cb_d;
   logic [4:0]      idx_q, idx_d;       // CBW / CSW byte index
   logic [31:0]     remain_q, remain_d; // bytes left in the data phase (residue)
   logic [PktW-1:0] pkt_q, pkt_d;       // byte position within current packet
   logic [31:0]     csw_sig_q, csw_sig_d;
   logic [31:0]     csw_tag_q, csw_tag_d;
   logic [31:0]     csw_res_q, csw_res_d;
   logic [7:0]      csw_st_q, csw_st_d;
   logic            frame_err_q, frame_err_d;
   logic [31:0]     sts_tag_q, sts_tag_d;

   logic [4:0]      cblen_clamp;
   logic [127:0]    cb_masked;
   logic [3:0]      cb_sel;
   logic [7:0]      cbw_byte;
   logic            pkt_full;

   logic            tx_valid, tx_last, rx_ready, wr_ready, rd_valid, rd_last;
   logic [7:0]      tx_data, rd_data;

   // Write-data framing comes from the byte count, not from the source.
   logic unused_wr_tlast;
   assign unused_wr_tlast = dat_wr.tlast;

   always_comb begin
      if (cmd_cblen_i == 5'd0) begin
         cblen_clamp = 5'd1;
      end else if (cmd_cblen_i > 5'd16) begin
         cblen_clamp = 5'd16;
      end else begin
         cblen_clamp = cmd_cblen_i;
      end
   end

   // CDB bytes beyond the command length are zeroed at latch time.
   always_comb begin
      cb_masked = '0;
      for (int k = 0; k < 16; k++) begin
         if (5'(k) < cblen_clamp) begin
            cb_masked[8*k +: 8] = cmd_cb_i[8*k +: 8];
         end
      end
   end

   assign cb_sel = 4'(idx_q - 5'd15);

   always_comb begin
      case (idx_q)
         5'd0:    cbw_byte = 8'h55;
         5'd1:    cbw_byte = 8'h53;
         5'd2:    cbw_byte = 8'h42;
         5'd3:    cbw_byte = 8'h43;
         5'd4:    cbw_byte = tag_q[7:0];
         5'd5:    cbw_byte = tag_q[15:8];
         5'd6:    cbw_byte = tag_q[23:16];
         5'd7:    cbw_byte = tag_q[31:24];
         5'd8:    cbw_byte = len_q[7:0];
         5'd9:    cbw_byte = len_q[15:8];
         5'd10:   cbw_byte = len_q[23:16];
         5'd11:   cbw_byte = len_q[31:24];
         5'd12:   cbw_byte = {dir_q, 7'b0};
         5'd13:   cbw_byte = {4'b0, lun_q};
         5'd14:   cbw_byte = {3'b0, cblen_q};
         default: cbw_byte = cb_q[{cb_sel, 3'b000} +: 8];
      endcase
   end

   assign pkt_full = (pkt_q == PktLast);

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      dir_d       = dir_q;
      lun_d       = lun_q;
      len_d       = len_q;
      cblen_d     = cblen_q;
      cb_d        = cb_q;
      idx_d       = idx_q;
      remain_d    = remain_q;
      pkt_d       = pkt_q;
      csw_sig_d   = csw_sig_q;
      csw_tag_d   = csw_tag_q;
      csw_res_d   = csw_res_q;
      csw_st_d    = csw_st_q;
      frame_err_d = frame_err_q;
      sts_tag_d   = sts_tag_q;
      tx_valid    = 1'b0;
      tx_last     = 1'b0;
      tx_data     = 8'h00;
      rx_ready    = 1'b0;
      wr_ready    = 1'b0;
      rd_valid    = 1'b0;
      rd_last     = 1'b0;
      rd_data     = 8'h00;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               dir_d       = cmd_dir_i;
               lun_d       = cmd_lun_i;
               len_d       = cmd_len_i;
               cblen_d     = cblen_clamp;
               cb_d        = cb_masked;
               remain_d    = cmd_len_i;
               idx_d       = '0;
               pkt_d       = '0;
               csw_sig_d   = '0;
               csw_tag_d   = '0;
               csw_res_d   = '0;
               csw_st_d    = '0;
               frame_err_d = 1'b0;
               state_d     = StCbw;
            end
         end

         StCbw: begin
            tx_valid = 1'b1;
            tx_data  = cbw_byte;
            tx_last  = (idx_q == 5'd30);
            if (usb_tx.tready) begin
               if (idx_q == 5'd30) begin
                  idx_d = '0;
                  if (len_q == 32'd0) begin
                     state_d = StCsw;
                  end else if (dir_q) begin
                     state_d = StDin;
                  end else begin
                     state_d = StDout;
                  end
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end

         StDout: begin
            tx_valid = dat_wr.tvalid;
            tx_data  = dat_wr.tdata;
            tx_last  = (remain_q == 32'd1) || pkt_full;
            wr_ready = usb_tx.tready;
            if (dat_wr.tvalid && usb_tx.tready) begin
               remain_d = remain_q - 32'd1;
               pkt_d    = pkt_full ? '0 : pkt_q + 1'b1;
               if (remain_q == 32'd1) begin
                  state_d = StCsw;
               end
            end
         end

         StDin: begin
            rd_valid = usb_rx.tvalid;
            rd_data  = usb_rx.tdata;
            rd_last  = (remain_q == 32'd1) || usb_rx.tlast;
            rx_ready = dat_rd.tready;
            if (usb_rx.tvalid && dat_rd.tready) begin
               remain_d = remain_q - 32'd1;
               pkt_d    = (pkt_full || usb_rx.tlast) ? '0 : pkt_q + 1'b1;
               // tlast on a packet shorter than MAX_PACKET ends the data phase early.
               if ((remain_q == 32'd1) || (usb_rx.tlast && !pkt_full)) begin
                  state_d = StCsw;
               end
            end
         end

         StCsw: begin
            rx_ready = 1'b1;
            if (usb_rx.tvalid) begin
               if (idx_q < 5'd4) begin
                  csw_sig_d[{idx_q[1:0], 3'b000} +: 8] = usb_rx.tdata;
               end else if (idx_q < 5'd8) begin
                  csw_tag_d[{idx_q[1:0], 3'b000} +: 8] = usb_rx.tdata;
               end else if (idx_q < 5'd12) begin
                  csw_res_d[{idx_q[1:0], 3'b000} +: 8] = usb_rx.tdata;
               end else if (idx_q == 5'd12) begin
                  csw_st_d = usb_rx.tdata;
               end
               if ((usb_rx.tlast && (idx_q < 5'd12)) || (!usb_rx.tlast && (idx_q == 5'd12))) begin
                  frame_err_d = 1'b1;
               end
               if (usb_rx.tlast) begin
                  sts_tag_d = tag_q;
                  state_d   = StDone;
               end else if (idx_q != 5'd13) begin
                  // Index parks at 13 while draining an over-long CSW.
                  idx_d = idx_q + 5'd1;
               end
            end
         end

         StDone: begin
            tag_d   = tag_q + 32'd1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         tag_q       <= TAG_INIT;
         dir_q       <= 1'b0;
         lun_q       <= '0;
         len_q       <= '0;
         cblen_q     <= '0;
         cb_q        <= '0;
         idx_q       <= '0;
         remain_q    <= '0;
         pkt_q       <= '0;
         csw_sig_q   <= '0;
         csw_tag_q   <= '0;
         csw_res_q   <= '0;
         csw_st_q    <= '0;
         frame_err_q <= 1'b0;
         sts_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         dir_q       <= dir_d;
         lun_q       <= lun_d;
         len_q       <= len_d;
         cblen_q     <= cblen_d;
         cb_q        <= cb_d;
         idx_q       <= idx_d;
         remain_q    <= remain_d;
         pkt_q       <= pkt_d;
         csw_sig_q   <= csw_sig_d;
         csw_tag_q   <= csw_tag_d;
         csw_res_q   <= csw_res_d;
         csw_st_q    <= csw_st_d;
         frame_err_q <= frame_err_d;
         sts_tag_q   <= sts_tag_d;
      end
   end

   assign usb_tx.tvalid = tx_valid;
   assign usb_tx.tlast  = tx_last;
   assign usb_tx.tdata  = tx_data;
   assign usb_rx.tready = rx_ready;
   assign dat_wr.tready = wr_ready;
   assign dat_rd.tvalid = rd_valid;
   assign dat_rd.tlast  = rd_last;
   assign dat_rd.tdata  = rd_data;

   assign cmd_ready_o   = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign sts_valid_o   = (state_q == StDone);
   assign sts_tag_o     = sts_tag_q;
   assign sts_residue_o = csw_res_q;
   assign sts_status_o  = csw_st_q;
   // tag_q still holds the issued tag during StDone; it increments on leaving.
   assign sts_error_o   = (state_q == StDone) &&
                          ((csw_sig_q != CswSig) || (csw_tag_q != tag_q) ||
                           frame_err_q || (csw_st_q > 8'd2));

endmodule
